ps2_kb_rx: RTL and testbench
============================

// Module: ps2_kb_rx
// PURPOSE
//  PS/2 keyboard receiver feeding the memIO keyboard read path (16-bit code, zero-extended on CPU read).
//  Synchronises and glitch-filters ps2_clk/ps2_data, deframes 11-bit device->host frames, checks odd parity,
//  folds E0 (extended) and F0 (break) prefixes into one key-event word, holds it until the next event.
// PARAMETERS
//  FILTER_LEN   8        cycles synced ps2_clk must be stable before filtered level changes (1..255)
//  TIMEOUT_CYC  100000   cycles without a falling edge mid-frame before frame is aborted (2ms @50MHz)
// PORTS
//  clk        in   1   system clock; sole clock domain
//  rst        in   1   synchronous reset, active-high
//  ps2_clk    in   1   raw PS/2 clock from pin, asynchronous
//  ps2_data   in   1   raw PS/2 data from pin, asynchronous
//  kb_code    out  16  last key event: [15]=break, [14]=extended, [13:8]=0, [7:0]=scancode
//  kb_strobe  out  1   one-cycle pulse when kb_code updates
//  frame_err  out  1   one-cycle pulse on parity/stop error or timeout abort
// BEHAVIOUR
//  Reset (rst=1 at posedge): kb_code=0, kb_strobe=0, frame_err=0, state=IDLE, sync/filter regs=1,
//   bit count=0, pending brk/ext=0, timeout counter=0. Reset mid-frame discards partial frame.
//  Input conditioning: 2-FF synchroniser on each of ps2_clk, ps2_data (reset to 1).
//   Filter: counter increments while synced clk != filtered clk, else clears; at FILTER_LEN filtered clk
//   takes synced value, counter clears. fall = filtered 1->0 this cycle (registered previous value).
//   Data sampled = synced ps2_data in the fall cycle.
//  FSM (advances only on fall, except timeout):
//   IDLE   : fall & data==0 -> DATA, bitcnt=0. fall & data==1 -> stay IDLE (no error).
//   DATA   : shift data into shreg LSB-first (bit i -> shreg[i]); bitcnt++; after 8th bit -> PARITY.
//   PARITY : store p; -> STOP.
//   STOP   : good = (data==1) & (^shreg ^ p)==1 (odd parity). -> IDLE either way.
//  Frame completion (STOP fall at cycle N), registered at N+1:
//   good & byte==8'hE0 : ext_pend=1; no strobe.
//   good & byte==8'hF0 : brk_pend=1; no strobe (ext_pend kept, so E0 F0 xx gives both flags).
//   good & other       : kb_code={brk_pend,ext_pend,6'b0,byte}; kb_strobe=1; brk_pend=ext_pend=0.
//   bad                : frame_err=1; kb_code unchanged; brk_pend=ext_pend=0.
//  Timeout: counter clears on every fall and in IDLE; counts otherwise. Reaching TIMEOUT_CYC-1 in
//   DATA/PARITY/STOP -> IDLE next cycle, frame_err pulse, pending prefixes cleared, counter cleared.
//  Simultaneous: a fall in the same cycle timeout fires is ignored (timeout wins).
//  kb_strobe and frame_err never both high; each exactly one cycle. Minimum event spacing is one
//   frame (~11 PS/2 clocks) so no output buffering required; consumer samples kb_code at any time.
//  No host->device transmit; ps2 lines are inputs only.
// TESTING
//  T1 frame 0x1C (data 0011_1000 LSB first, parity 0, stop 1) -> kb_code=16'h001C, one kb_strobe.
//  T2 frames E0,F0,75 -> no strobe after E0/F0; after 75 kb_code=16'hC075, pending flags cleared;
//     then frame 75 -> kb_code=16'h0075.
//  T3 frame 0x1C with parity=1 -> frame_err pulse, kb_code keeps prior value, no strobe;
//     F0 then bad frame then 1C -> kb_code=16'h001C (break cleared).
//  T4 1-cycle and FILTER_LEN-1-cycle low glitches on ps2_clk while IDLE/mid-frame -> no bit sampled,
//     following valid frame decodes correctly.
//  T5 stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles (use TIMEOUT_CYC=500) -> frame_err at
//     timeout, state IDLE; next full frame 0x29 -> kb_code=16'h0029.
//  T6 assert rst mid-frame (after bit 5) -> all outputs 0 next cycle; next frame 0x5A -> 16'h005A.

Source files
------------

// File: rtl/ps2_kb_rx_if.sv
// Bundle of PS/2 pins and the decoded key-event outputs of ps2_kb_rx.
// kb_code is a held value. kb_strobe and frame_err are single-cycle pulses with no ready/backpressure.
// The consumer may sample kb_code in any cycle.
interface ps2_kb_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] kb_code;
  logic        kb_strobe;
  logic        frame_err;
  logic [1:0]  fsm_state;

  modport master (
    output ps2_clk, ps2_data,
    input  kb_code, kb_strobe, frame_err, fsm_state
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output kb_code, kb_strobe, frame_err, fsm_state
  );
endinterface

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver. It synchronises and glitch-filters the PS/2 lines and deframes 11-bit frames.
// E0/F0 prefixes are folded into a single 16-bit key-event word.
module ps2_kb_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_kb_rx_if.slave   bus
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_q;
  logic [7:0]    filt_cnt;
  logic          fall;
  logic          timeout_hit;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic          brk_pend, ext_pend;
  logic [TW-1:0] tcnt;
  logic [15:0]   kb_code;
  logic          kb_strobe, frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= 8'd0;
    end else begin
      clk_s1     <= bus.ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= bus.ps2_data;
      dat_s2     <= dat_s1;
      clk_filt_q <= clk_filt;
      // The filtered clock only follows after FILTER_LEN consecutive disagreeing cycles.
      if (clk_s2 != clk_filt) begin
        if (filt_cnt == 8'(FILTER_LEN - 1)) begin
          clk_filt <= clk_s2;
          filt_cnt <= 8'd0;
        end else begin
          filt_cnt <= filt_cnt + 8'd1;
        end
      end else begin
        filt_cnt <= 8'd0;
      end
    end
  end

  assign fall        = clk_filt_q & ~clk_filt;
  assign timeout_hit = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= 3'd0;
      shreg     <= 8'd0;
      par       <= 1'b0;
      brk_pend  <= 1'b0;
      ext_pend  <= 1'b0;
      tcnt      <= '0;
      kb_code   <= 16'd0;
      kb_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      kb_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + TW'(1);

      // A timeout takes priority over a fall in the same cycle.
      if (timeout_hit) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        brk_pend  <= 1'b0;
        ext_pend  <= 1'b0;
        tcnt      <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state  <= DATA;
              bitcnt <= 3'd0;
            end
          end
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && (^shreg ^ par)) begin
              if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk_pend <= 1'b1;
              end else begin
                kb_code   <= {brk_pend, ext_pend, 6'b0, shreg};
                kb_strobe <= 1'b1;
                brk_pend  <= 1'b0;
                ext_pend  <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              brk_pend  <= 1'b0;
              ext_pend  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.kb_code   = kb_code;
  assign bus.kb_strobe = kb_strobe;
  assign bus.frame_err = frame_err;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx. It drives PS/2 frames at the pins and checks the decoded words.
// It also checks the strobe and error pulse counts.
module tb_ps2_kb_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   strobe_cnt = 0;
  int   err_cnt = 0;
  int   s_base = 0;
  int   e_base = 0;

  ps2_kb_rx_if bus ();

  ps2_kb_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(500)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.kb_strobe) strobe_cnt++;
    if (bus.frame_err) err_cnt++;
    if (bus.kb_strobe || bus.frame_err) begin
      n_cmp++;
      assert (!(bus.kb_strobe && bus.frame_err)) else begin
        n_bad++;
        $error("FAIL pulse_excl: strobe=%0b err=%0b required not both", bus.kb_strobe, bus.frame_err);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit of 60 cycles. When glitch is set, a 7-cycle low pulse is inserted in the high phase.
  task automatic send_bit(input logic b, input logic glitch);
    bus.ps2_data = b;
    wait_cyc(10);
    bus.ps2_clk = 1'b0;
    wait_cyc(30);
    bus.ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(5);
      bus.ps2_clk = 1'b0;
      wait_cyc(7);
      bus.ps2_clk = 1'b1;
      wait_cyc(8);
    end else begin
      wait_cyc(20);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_bit);
    bus.ps2_data = 1'b1;
    if (nbits == 11) wait_cyc(40);
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] code, input int ds, input int de);
    chk({tag, "_code"}, 32'(bus.kb_code), 32'(code));
    chk({tag, "_strobes"}, 32'(strobe_cnt - s_base), 32'(ds));
    chk({tag, "_errs"}, 32'(err_cnt - e_base), 32'(de));
    chk({tag, "_state"}, 32'(bus.fsm_state), 32'd0);
    s_base = strobe_cnt;
    e_base = err_cnt;
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    wait_cyc(4);
    chk("rst_code", 32'(bus.kb_code), 32'd0);
    chk("rst_strobe", 32'(bus.kb_strobe), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_state", 32'(bus.fsm_state), 32'd0);
    rst = 1'b0;
    wait_cyc(20);

    // T1: plain make code
    send_frame(8'h1C, 1'b0, 11, -1);
    expect_frame("t1_1c", 16'h001C, 1, 0);

    // T2: extended break sequence, then plain make
    send_frame(8'hE0, 1'b0, 11, -1);
    expect_frame("t2_e0", 16'h001C, 0, 0);
    send_frame(8'hF0, 1'b0, 11, -1);
    expect_frame("t2_f0", 16'h001C, 0, 0);
    send_frame(8'h75, 1'b0, 11, -1);
    expect_frame("t2_75brk", 16'hC075, 1, 0);
    send_frame(8'h75, 1'b0, 11, -1);
    expect_frame("t2_75", 16'h0075, 1, 0);

    // T3: parity errors, and a bad frame cancelling a pending break
    send_frame(8'h1C, 1'b1, 11, -1);
    expect_frame("t3_bad", 16'h0075, 0, 1);
    send_frame(8'hF0, 1'b0, 11, -1);
    expect_frame("t3_f0", 16'h0075, 0, 0);
    send_frame(8'h33, 1'b1, 11, -1);
    expect_frame("t3_bad2", 16'h0075, 0, 1);
    send_frame(8'h1C, 1'b0, 11, -1);
    expect_frame("t3_1c", 16'h001C, 1, 0);

    // T4: idle glitches with data low, then a frame with a mid-frame glitch
    bus.ps2_data = 1'b0;
    wait_cyc(10);
    bus.ps2_clk = 1'b0;
    wait_cyc(1);
    bus.ps2_clk = 1'b1;
    wait_cyc(20);
    bus.ps2_clk = 1'b0;
    wait_cyc(7);
    bus.ps2_clk = 1'b1;
    wait_cyc(20);
    bus.ps2_data = 1'b1;
    wait_cyc(20);
    expect_frame("t4_idle", 16'h001C, 0, 0);
    send_frame(8'h6B, 1'b0, 11, 4);
    expect_frame("t4_6b", 16'h006B, 1, 0);

    // T5: truncated frame times out
    send_frame(8'h29, 1'b0, 5, -1);
    wait_cyc(300);
    chk("t5_no_err_yet", 32'(err_cnt - e_base), 32'd0);
    chk("t5_in_data", 32'(bus.fsm_state), 32'd1);
    wait_cyc(300);
    expect_frame("t5_timeout", 16'h006B, 0, 1);
    send_frame(8'h29, 1'b0, 11, -1);
    expect_frame("t5_29", 16'h0029, 1, 0);

    // T6: reset mid-frame
    send_frame(8'h5A, 1'b0, 6, -1);
    chk("t6_mid_state", 32'(bus.fsm_state), 32'd1);
    rst = 1'b1;
    wait_cyc(1);
    chk("t6_rst_code", 32'(bus.kb_code), 32'd0);
    chk("t6_rst_strobe", 32'(bus.kb_strobe), 32'd0);
    chk("t6_rst_err", 32'(bus.frame_err), 32'd0);
    chk("t6_rst_state", 32'(bus.fsm_state), 32'd0);
    rst = 1'b0;
    wait_cyc(20);
    s_base = strobe_cnt;
    e_base = err_cnt;
    send_frame(8'h5A, 1'b0, 11, -1);
    expect_frame("t6_5a", 16'h005A, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
